// File: rtl/load_store_unit.sv
// load_store_unit: data-memory stage on a req/ack word bus.
// Optional LSU_TIMEOUT_EN aborts a REQ after TIMEOUT_CYC cycles.
module load_store_unit #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] readdata_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic [31:0] err_addr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] rdata_q;
    logic        mis_q;
    logic [31:0] err_q;
    logic        to_hit;

    logic        req_valid;
    logic        sz_byte;
    logic        sz_half;
    logic        sz_word;
    logic        misaligned;
    logic        start;
    logic        mis_evt;
    logic        ack_ok;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;

    // Request qualification and size decode from the incoming instruction
    always_comb begin
        req_valid  = memread_i | memwrite_i;
        sz_byte    = (funct3_i[1:0] == 2'b00);
        sz_half    = (funct3_i[1:0] == 2'b01);
        sz_word    = ~sz_byte & ~sz_half;
        misaligned = (sz_half & addr_i[0]) | (sz_word & (|addr_i[1:0]));
        start      = (state_q == IDLE) & req_valid & ~misaligned;
        mis_evt    = (state_q == IDLE) & req_valid & misaligned;
        ack_ok     = (state_q == REQ) & bus_ack_i;
    end

    // Byte enables and lane-replicated store data
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = wdata_i;
        if (sz_byte) begin
            be_d    = 4'b0001 << addr_i[1:0];
            wdata_d = {4{wdata_i[7:0]}};
        end else if (sz_half) begin
            be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{wdata_i[15:0]}};
        end
    end

    // Lane select by registered offset, then extend per registered funct3
    always_comb begin
        case (off_q)
            2'd0:    lane_b = bus_rdata_i[7:0];
            2'd1:    lane_b = bus_rdata_i[15:8];
            2'd2:    lane_b = bus_rdata_i[23:16];
            default: lane_b = bus_rdata_i[31:24];
        endcase
        lane_h = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_ext = {24'h0, lane_b};
            3'b101:  load_ext = {16'h0, lane_h};
            default: load_ext = bus_rdata_i;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;

    logic [CW-1:0] cnt_q;
    logic          to_q;

    assign to_hit = (state_q == REQ) & ~bus_ack_i &
                    (cnt_q == CW'(TIMEOUT_CYC - 1));

    // Wait counter restarts on REQ entry; sticky timeout flag
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            if (start)
                cnt_q <= '0;
            else if ((state_q == REQ) & ~bus_ack_i)
                cnt_q <= cnt_q + 1'b1;
            if (to_hit)
                to_q <= 1'b1;
        end
    end

    assign misalign_o = mis_q | to_q;
`else
    assign to_hit     = 1'b0;
    assign misalign_o = mis_q;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = REQ;
            REQ:     if (bus_ack_i | to_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        bus_req_o = (state_q == REQ);
        stall_o   = start | (state_q == REQ);
    end

    // Bus request registers, load result and misalignment capture
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            if (start) begin
                we_q    <= memwrite_i;
                addr_q  <= {addr_i[31:2], 2'b00};
                wdata_q <= wdata_d;
                be_q    <= be_d;
                f3_q    <= funct3_i;
                off_q   <= addr_i[1:0];
            end
            if (ack_ok & ~we_q)
                rdata_q <= load_ext;
            else if (to_hit)
                rdata_q <= '0;
            if (mis_evt) begin
                mis_q <= 1'b1;
                if (!mis_q)
                    err_q <= addr_i;
            end
        end
    end

    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign bus_be_o    = be_q;
    assign readdata_o  = rdata_q;
    assign err_addr_o  = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus hand sequences
// for misalignment, reset during REQ and the REQ timeout.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread;
    logic        memwrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] readdata;
    logic        stall;
    logic        misalign;
    logic [31:0] err_addr;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYC(16)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .memread_i   (memread),
        .memwrite_i  (memwrite),
        .funct3_i    (funct3),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .bus_rdata_i (bus_rdata),
        .bus_ack_i   (bus_ack),
        .bus_req_o   (bus_req),
        .bus_we_o    (bus_we),
        .bus_addr_o  (bus_addr),
        .bus_wdata_o (bus_wdata),
        .bus_be_o    (bus_be),
        .readdata_o  (readdata),
        .stall_o     (stall),
        .misalign_o  (misalign),
        .err_addr_o  (err_addr)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;
        logic [3:0]  be;
        logic [31:0] bwdata;
        int          nstall;
        logic [31:0] rdout;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int ns;
        int k;
        bit done;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        memread   = v.rd;
        memwrite  = v.wr;
        funct3    = v.f3;
        addr      = v.addr;
        wdata     = v.wdata;
        bus_rdata = v.rdata;
        #1;
        ns = stall ? 1 : 0;
        @(negedge clk);
        memread  = 1'b0;
        memwrite = 1'b0;
        chk({tag, ".req"}, {31'h0, bus_req}, 32'h1);
        chk({tag, ".we"}, {31'h0, bus_we}, {31'h0, v.wr});
        chk({tag, ".addr"}, bus_addr, {v.addr[31:2], 2'b00});
        chk({tag, ".be"}, {28'h0, bus_be}, {28'h0, v.be});
        if (v.wr)
            chk({tag, ".wdata"}, bus_wdata, v.bwdata);
        k = 0;
        done = 1'b0;
        while (!done && k < 40) begin
            if (stall) ns++;
            bus_ack = (k == v.dly);
            @(negedge clk);
            bus_ack = 1'b0;
            if (!stall) done = 1'b1;
            k++;
        end
        chk({tag, ".stallcyc"}, ns, v.nstall);
        chk({tag, ".reqdone"}, {31'h0, bus_req}, 32'h0);
        chk({tag, ".rdata"}, readdata, v.rdout);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,
                     32'h800000F0, 0, 4'b1111, 32'h0, 2, 32'h800000F0};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,
                     32'h80223344, 1, 4'b1000, 32'h0, 3, 32'hFFFFFF80};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,
                     32'h80223344, 0, 4'b1000, 32'h0, 2, 32'h00000080};
        vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD,
                     32'hFFFFFFFF, 2, 4'b1100, 32'hABCDABCD, 4, 32'h00000080};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,
                     32'h80223344, 0, 4'b1100, 32'h0, 2, 32'hFFFF8022};
        vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0,
                     32'h80229344, 1, 4'b0011, 32'h0, 3, 32'h00009344};
        vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h101, 32'h000000A5,
                     32'h0, 0, 4'b0010, 32'hA5A5A5A5, 2, 32'h00009344};
        vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h300, 32'hDEADBEEF,
                     32'h0, 1, 4'b1111, 32'hDEADBEEF, 3, 32'h00009344};
        vecs[8]  = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0,
                     32'h80223344, 0, 4'b0010, 32'h0, 2, 32'h00000033};
        vecs[9]  = '{1'b1, 1'b1, 3'b010, 32'h010, 32'h11223344,
                     32'h55667788, 0, 4'b1111, 32'h11223344, 2, 32'h00000033};
        vecs[10] = '{1'b1, 1'b0, 3'b011, 32'h020, 32'h0,
                     32'hCAFEF00D, 2, 4'b1111, 32'h0, 4, 32'hCAFEF00D};
        vecs[11] = '{1'b0, 1'b1, 3'b100, 32'h003, 32'h00000077,
                     32'h0, 0, 4'b1000, 32'h77777777, 2, 32'hCAFEF00D};

        reset     = 1'b1;
        memread   = 1'b0;
        memwrite  = 1'b0;
        funct3    = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
        bus_rdata = 32'h0;
        bus_ack   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.req", {31'h0, bus_req}, 32'h0);
        chk("rst.be", {28'h0, bus_be}, 32'h0);
        chk("rst.addr", bus_addr, 32'h0);
        chk("rst.rdata", readdata, 32'h0);
        chk("rst.mis", {31'h0, misalign}, 32'h0);
        chk("rst.err", err_addr, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            run_vec(i, vecs[i]);

        // misaligned word load: no bus cycle, flag and address captured
        @(negedge clk);
        memread = 1'b1;
        funct3  = 3'b010;
        addr    = 32'h101;
        #1;
        chk("mis1.stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        memread = 1'b0;
        chk("mis1.req", {31'h0, bus_req}, 32'h0);
        chk("mis1.flag", {31'h0, misalign}, 32'h1);
        chk("mis1.err", err_addr, 32'h101);
        chk("mis1.rdata", readdata, 32'hCAFEF00D);
        // second misaligned access keeps the first address
        memwrite = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h203;
        #1;
        chk("mis2.stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        memwrite = 1'b0;
        chk("mis2.req", {31'h0, bus_req}, 32'h0);
        chk("mis2.err", err_addr, 32'h101);
        chk("mis2.flag", {31'h0, misalign}, 32'h1);

        // reset in the second REQ cycle, late ack ignored
        @(negedge clk);
        memread   = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h040;
        bus_rdata = 32'h13579BDF;
        @(negedge clk);
        memread = 1'b0;
        chk("rreq.req", {31'h0, bus_req}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        bus_ack = 1'b1;
        #1;
        chk("rreq.req0", {31'h0, bus_req}, 32'h0);
        chk("rreq.stall", {31'h0, stall}, 32'h0);
        chk("rreq.rdata", readdata, 32'h0);
        chk("rreq.mis", {31'h0, misalign}, 32'h0);
        chk("rreq.addr", bus_addr, 32'h0);
        @(negedge clk);
        bus_ack = 1'b0;
        chk("rreq.ackign", {31'h0, bus_req}, 32'h0);
        chk("rreq.rdata2", readdata, 32'h0);

        // REQ with no ack: timeout or indefinite wait
        begin
            int ns;
            int k;
            @(negedge clk);
            memread   = 1'b1;
            funct3    = 3'b010;
            addr      = 32'h080;
            bus_rdata = 32'h12345678;
            @(negedge clk);
            memread = 1'b0;
            ns = 0;
            k  = 0;
`ifdef LSU_TIMEOUT_EN
            while (stall && k < 40) begin
                ns++;
                @(negedge clk);
                k++;
            end
            chk("to.reqcyc", ns, 16);
            chk("to.req", {31'h0, bus_req}, 32'h0);
            chk("to.rdata", readdata, 32'h0);
            chk("to.mis", {31'h0, misalign}, 32'h1);
`else
            repeat (20) @(negedge clk);
            chk("nto.stall", {31'h0, stall}, 32'h1);
            chk("nto.req", {31'h0, bus_req}, 32'h1);
            bus_ack = 1'b1;
            @(negedge clk);
            bus_ack = 1'b0;
            chk("nto.stall0", {31'h0, stall}, 32'h0);
            chk("nto.rdata", readdata, 32'h12345678);
            chk("nto.mis", {31'h0, misalign}, 32'h0);
`endif
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
